// File: rtl/encoder_quad_if.sv
// Quadrature encoder interface: synchronised, glitch-filtered A/B/Z inputs, x4/x2/x1 decoding,
// preload, illegal-transition flag and windowed velocity. Optional index logic: define ENC_INDEX_EN.
module encoder_quad_if #(
    parameter int CNT_W    = 64,
    parameter int FILT_LEN = 3,
    parameter int PER_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    phaseA,
    input  logic                    phaseB,
    input  logic                    phaseZ,
    input  logic [1:0]              mode,
    input  logic                    load,
    input  logic signed [CNT_W-1:0] load_val,
    input  logic [PER_W-1:0]        sample_period,
    input  logic                    err_clr,
    input  logic                    index_arm,
    output logic signed [CNT_W-1:0] pulse_count,
    output logic signed [CNT_W-1:0] pulse_diff,
    output logic                    vel_valid,
    output logic                    dir,
    output logic                    err_sticky,
    output logic                    index_seen,
    output logic signed [CNT_W-1:0] index_pos
);

    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

`ifdef ENC_INDEX_EN
    localparam int NCH = 3;
    logic [NCH-1:0] raw;
    assign raw = {phaseZ, phaseB, phaseA};
`else
    localparam int NCH = 2;
    logic [NCH-1:0] raw;
    logic           unused_index;
    assign raw          = {phaseB, phaseA};
    assign unused_index = phaseZ ^ index_arm;
`endif

    logic [NCH-1:0] sync1, sync2, filt;
    logic [FCW-1:0] fcnt [NCH];

    // Per channel: 2-flop synchroniser, then a level must differ for FILT_LEN cycles to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < NCH; i++) fcnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync1 -> sync2 a true two-stage pipeline.
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCW'(1);
                end
            end
        end
    end

    logic [1:0] cur_ab, prev_ab, pos_diff;
    logic       a_chg, b_chg, step_up, step_dn, illegal, index_clr;
    logic signed [CNT_W-1:0] delta;

    assign cur_ab = {filt[0], filt[1]};

    // Position of {A,B} along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        step_up  = 1'b0;
        step_dn  = 1'b0;
        illegal  = 1'b0;
        a_chg    = cur_ab[1] ^ prev_ab[1];
        b_chg    = cur_ab[0] ^ prev_ab[0];
        pos_diff = gray_pos(cur_ab) - gray_pos(prev_ab);
        if (a_chg && b_chg) begin
            illegal = 1'b1;
        end else begin
            case (mode)
                2'b01: if (a_chg) begin
                    step_up = cur_ab[1] ^ cur_ab[0];
                    step_dn = ~(cur_ab[1] ^ cur_ab[0]);
                end
                2'b10: if (a_chg && cur_ab[1]) begin
                    step_up = ~cur_ab[0];
                    step_dn = cur_ab[0];
                end
                default: if (a_chg || b_chg) begin
                    step_up = (pos_diff == 2'd1);
                    step_dn = (pos_diff != 2'd1);
                end
            endcase
        end
        delta = step_up ? CNT_W'(1) : (step_dn ? {CNT_W{1'b1}} : '0);
    end

    logic [PER_W-1:0]        timer;
    logic signed [CNT_W-1:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ab     <= '0;
            pulse_count <= '0;
            pulse_diff  <= '0;
            vel_valid   <= 1'b0;
            dir         <= 1'b0;
            err_sticky  <= 1'b0;
            timer       <= '0;
            acc         <= '0;
        end else begin
            prev_ab   <= cur_ab;
            vel_valid <= 1'b0;

            if (illegal)      err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;

            if (step_up || step_dn) dir <= step_up;

            if (load)           pulse_count <= load_val;
            else if (index_clr) pulse_count <= '0;
            else                pulse_count <= pulse_count + delta;

            // The accumulator always sees the step, even when load or index overrides the count.
            if (sample_period == '0) begin
                timer <= '0;
                acc   <= acc + delta;
            end else if (timer >= sample_period - PER_W'(1)) begin
                pulse_diff <= acc + delta;
                acc        <= '0;
                timer      <= '0;
                vel_valid  <= 1'b1;
            end else begin
                timer <= timer + PER_W'(1);
                acc   <= acc + delta;
            end
        end
    end

`ifdef ENC_INDEX_EN
    logic z_prev, z_rise;
    assign z_rise    = filt[2] & ~z_prev;
    assign index_clr = z_rise & index_arm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_prev     <= 1'b0;
            index_seen <= 1'b0;
            index_pos  <= '0;
        end else begin
            z_prev <= filt[2];
            if (z_rise) index_seen <= 1'b1;
            if (index_clr) index_pos <= pulse_count;
        end
    end
`else
    assign index_clr  = 1'b0;
    assign index_seen = 1'b0;
    assign index_pos  = '0;
`endif

endmodule
